// File: rtl/selector_scan_decoder.sv
// ---------------------------------------------------------------------------
// selector_scan_decoder
//
// Purpose:
//    Registered one-hot channel selector with three behaviours chosen by mode:
//    - input (mode 0): captures a channel index on a load strobe.
//    - debug (mode 2): scans every channel in turn, each one held for dwell+1
//      cycles. The scan can be frozen with hold.
//    - run/reserved (modes 1, 3): all enables low.
//    The enable vector is always onehot(index) in input/scan and zero when off.
//
// Ports:
//    clk       in   system clock, all state on rising edge
//    rst       in   synchronous, active-high reset
//    mode      in   [1:0]  0=input, 1=run, 2=debug scan, 3=reserved (as run)
//    selector  in   [SEL_W-1:0]   index captured in input mode
//    load      in   capture strobe for selector (input mode only)
//    hold      in   freezes scan progression in debug mode
//    dwell     in   [DWELL_W-1:0] each scanned channel is held dwell+1 cycles
//    out       out  [2**SEL_W-1:0] registered one-hot enable vector
//    index     out  [SEL_W-1:0]   registered current channel index
//    strobe    out  one-cycle pulse when out takes a new non-zero value
//    scanning  out  high while in the scan state
// ---------------------------------------------------------------------------
module selector_scan_decoder #(
   parameter int SEL_W   = 4,
   parameter int DWELL_W = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [1:0]              mode,
   input  logic [SEL_W-1:0]        selector,
   input  logic                    load,
   input  logic                    hold,
   input  logic [DWELL_W-1:0]      dwell,
   output logic [(1<<SEL_W)-1:0]   out,
   output logic [SEL_W-1:0]        index,
   output logic                    strobe,
   output logic                    scanning
);

   localparam int N = 1 << SEL_W;

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_INPUT = 2'd1,
      ST_SCAN  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [N-1:0]         out_q, out_d;
   logic [SEL_W-1:0]     index_q, index_d;
   logic [DWELL_W-1:0]   cnt_q, cnt_d;
   logic                 strobe_q, strobe_d;
   logic                 scanning_q, scanning_d;

   // Next-state and next-output logic. The state follows mode every cycle;
   // all outputs are computed for the state being entered so they register
   // on the same edge as the state itself.
   always_comb begin
      state_d    = ST_OFF;
      index_d    = index_q;
      cnt_d      = '0;
      out_d      = '0;

      case (mode)
         2'd0:    state_d = ST_INPUT;
         2'd2:    state_d = ST_SCAN;
         default: state_d = ST_OFF;
      endcase

      case (state_d)
         ST_INPUT: begin
            // A load on the entry cycle wins over the retained index.
            if (load) begin
               index_d = selector;
            end
            out_d[index_d] = 1'b1;
         end
         ST_SCAN: begin
            if (state_q != ST_SCAN) begin
               // Every scan starts from channel 0 with a fresh dwell count,
               // whatever was in progress before leaving scan mode.
               index_d = '0;
               cnt_d   = '0;
            end else if (hold) begin
               cnt_d   = cnt_q;
            end else if (cnt_q >= dwell) begin
               // ">=" rather than "==" so that lowering dwell below the
               // current count advances on the next cycle instead of
               // running the counter all the way round.
               index_d = index_q + SEL_W'(1);
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + DWELL_W'(1);
            end
            out_d[index_d] = 1'b1;
         end
         default: begin
            // Off: enables low, index retained, dwell count discarded.
         end
      endcase

      strobe_d   = (out_d != '0) && (out_d != out_q);
      scanning_d = (state_d == ST_SCAN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_OFF;
         out_q      <= '0;
         index_q    <= '0;
         cnt_q      <= '0;
         strobe_q   <= 1'b0;
         scanning_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         out_q      <= out_d;
         index_q    <= index_d;
         cnt_q      <= cnt_d;
         strobe_q   <= strobe_d;
         scanning_q <= scanning_d;
      end
   end

   assign out      = out_q;
   assign index    = index_q;
   assign strobe   = strobe_q;
   assign scanning = scanning_q;

endmodule

// File: tb/tb_selector_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_selector_scan_decoder
//
// Purpose:
//    Directed-vector scoreboard bench for selector_scan_decoder. Two
//    instances: SEL_W=4 (16 channels) and SEL_W=3 (8 channels). The driver
//    applies one vector per cycle on the falling edge and pushes the
//    hand-computed response expected after the next rising edge; a separate
//    monitor pops and compares one entry per cycle.
// ---------------------------------------------------------------------------
module tb_selector_scan_decoder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: SEL_W = 4
   logic        a_rst = 1'b1;
   logic [1:0]  a_mode = 2'd1;
   logic [3:0]  a_sel = '0;
   logic        a_load = 1'b0;
   logic        a_hold = 1'b0;
   logic [7:0]  a_dwell = '0;
   logic [15:0] a_out;
   logic [3:0]  a_index;
   logic        a_strobe;
   logic        a_scanning;

   // Instance B: SEL_W = 3
   logic        b_rst = 1'b1;
   logic [1:0]  b_mode = 2'd1;
   logic [2:0]  b_sel = '0;
   logic        b_load = 1'b0;
   logic        b_hold = 1'b0;
   logic [7:0]  b_dwell = '0;
   logic [7:0]  b_out;
   logic [2:0]  b_index;
   logic        b_strobe;
   logic        b_scanning;

   selector_scan_decoder #(.SEL_W(4), .DWELL_W(8)) dut_a (
      .clk      (clk),
      .rst      (a_rst),
      .mode     (a_mode),
      .selector (a_sel),
      .load     (a_load),
      .hold     (a_hold),
      .dwell    (a_dwell),
      .out      (a_out),
      .index    (a_index),
      .strobe   (a_strobe),
      .scanning (a_scanning)
   );

   selector_scan_decoder #(.SEL_W(3), .DWELL_W(8)) dut_b (
      .clk      (clk),
      .rst      (b_rst),
      .mode     (b_mode),
      .selector (b_sel),
      .load     (b_load),
      .hold     (b_hold),
      .dwell    (b_dwell),
      .out      (b_out),
      .index    (b_index),
      .strobe   (b_strobe),
      .scanning (b_scanning)
   );

   typedef struct packed {
      int unsigned id;
      logic [15:0] out;
      logic [3:0]  idx;
      logic        strobe;
      logic        scan;
   } exp_a_t;

   typedef struct packed {
      int unsigned id;
      logic [7:0]  out;
      logic [2:0]  idx;
      logic        strobe;
      logic        scan;
   } exp_b_t;

   exp_a_t      q_a[$];
   exp_b_t      q_b[$];
   int          checks = 0;
   int          errors = 0;
   int unsigned vec_id = 0;

   // Apply one vector to instance A and queue the response due after the
   // following rising edge.
   task automatic drive_a(input logic r, input logic [1:0] m, input logic [3:0] s,
                          input logic l, input logic h, input logic [7:0] d,
                          input logic [15:0] eo, input logic [3:0] ei,
                          input logic es, input logic esc);
      exp_a_t e;
      @(negedge clk);
      a_rst = r; a_mode = m; a_sel = s; a_load = l; a_hold = h; a_dwell = d;
      e.id = vec_id; e.out = eo; e.idx = ei; e.strobe = es; e.scan = esc;
      q_a.push_back(e);
      vec_id++;
   endtask

   task automatic drive_b(input logic r, input logic [1:0] m, input logic [2:0] s,
                          input logic l, input logic [7:0] d,
                          input logic [7:0] eo, input logic [2:0] ei,
                          input logic es, input logic esc);
      exp_b_t e;
      @(negedge clk);
      b_rst = r; b_mode = m; b_sel = s; b_load = l; b_hold = 1'b0; b_dwell = d;
      e.id = vec_id; e.out = eo; e.idx = ei; e.strobe = es; e.scan = esc;
      q_b.push_back(e);
      vec_id++;
   endtask

   // Monitor: one response per instance per cycle, sampled 1 time unit
   // after the rising edge.
   initial begin
      exp_a_t ea;
      exp_b_t eb;
      forever begin
         @(posedge clk);
         #1;
         if (q_a.size() > 0) begin
            ea = q_a.pop_front();
            checks++;
            if (a_out !== ea.out || a_index !== ea.idx ||
                a_strobe !== ea.strobe || a_scanning !== ea.scan) begin
               errors++;
               $display("FAIL A vec%0d: got out=%h index=%0d strobe=%b scanning=%b, want out=%h index=%0d strobe=%b scanning=%b",
                        ea.id, a_out, a_index, a_strobe, a_scanning,
                        ea.out, ea.idx, ea.strobe, ea.scan);
            end else begin
               $display("ok   A vec%0d: out=%h index=%0d strobe=%b scanning=%b",
                        ea.id, a_out, a_index, a_strobe, a_scanning);
            end
         end
         if (q_b.size() > 0) begin
            eb = q_b.pop_front();
            checks++;
            if (b_out !== eb.out || b_index !== eb.idx ||
                b_strobe !== eb.strobe || b_scanning !== eb.scan) begin
               errors++;
               $display("FAIL B vec%0d: got out=%h index=%0d strobe=%b scanning=%b, want out=%h index=%0d strobe=%b scanning=%b",
                        eb.id, b_out, b_index, b_strobe, b_scanning,
                        eb.out, eb.idx, eb.strobe, eb.scan);
            end else begin
               $display("ok   B vec%0d: out=%h index=%0d strobe=%b scanning=%b",
                        eb.id, b_out, b_index, b_strobe, b_scanning);
            end
         end
      end
   end

   // Watchdog so the run can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]  ei;
      logic [15:0] eo;
      logic [2:0]  bi;
      logic [7:0]  bo;

      // ---------------- Instance A ----------------
      // Reset state
      drive_a(1, 2'd1, 4'h0, 0, 0, 8'd0, 16'h0000, 4'd0, 0, 0);
      drive_a(1, 2'd0, 4'h5, 1, 0, 8'd0, 16'h0000, 4'd0, 0, 0);
      // Load 0xA: 1-cycle latency, strobe
      drive_a(0, 2'd0, 4'hA, 1, 0, 8'd0, 16'h0400, 4'd10, 1, 0);
      drive_a(0, 2'd0, 4'h0, 0, 0, 8'd0, 16'h0400, 4'd10, 0, 0);
      // Reload same index: no strobe
      drive_a(0, 2'd0, 4'hA, 1, 0, 8'd0, 16'h0400, 4'd10, 0, 0);
      // Run and reserved: out cleared, index retained
      drive_a(0, 2'd1, 4'h0, 0, 0, 8'd0, 16'h0000, 4'd10, 0, 0);
      drive_a(0, 2'd3, 4'h0, 0, 0, 8'd0, 16'h0000, 4'd10, 0, 0);
      // Back to input without load: retained index, strobe
      drive_a(0, 2'd0, 4'h0, 0, 0, 8'd0, 16'h0400, 4'd10, 1, 0);
      drive_a(0, 2'd0, 4'h3, 1, 0, 8'd0, 16'h0008, 4'd3, 1, 0);

      // Scan, dwell=2: each channel held 3 cycles, wraps after channel 15
      for (int t = 0; t < 51; t++) begin
         ei = 4'((t / 3) % 16);
         eo = 16'h0001 << ei;
         drive_a(0, 2'd2, 4'hF, 0, 0, 8'd2, eo, ei, (t % 3) == 0, 1);
      end
      // Leave scan: out zero, index retained (last scanned index was 0)
      drive_a(0, 2'd1, 4'h0, 0, 0, 8'd2, 16'h0000, 4'd0, 0, 0);

      // Scan, dwell=0: advance every cycle up to channel 5
      for (int t = 0; t < 6; t++) begin
         ei = 4'(t);
         eo = 16'h0001 << ei;
         drive_a(0, 2'd2, 4'h0, 0, 0, 8'd0, eo, ei, 1, 1);
      end
      // Hold for 4 cycles at channel 5: frozen, no strobe
      for (int t = 0; t < 4; t++) begin
         drive_a(0, 2'd2, 4'h0, 0, 1, 8'd0, 16'h0020, 4'd5, 0, 1);
      end
      drive_a(0, 2'd2, 4'h0, 0, 0, 8'd0, 16'h0040, 4'd6, 1, 1);
      drive_a(0, 2'd2, 4'h0, 0, 0, 8'd0, 16'h0080, 4'd7, 1, 1);
      // Reset mid-scan at channel 7 with load/mode 0: reset dominates
      drive_a(1, 2'd0, 4'hC, 1, 0, 8'd0, 16'h0000, 4'd0, 0, 0);
      // Load still high the next cycle: selector captured
      drive_a(0, 2'd0, 4'hC, 1, 0, 8'd0, 16'h1000, 4'd12, 1, 0);

      // Scan with dwell=5, then lower dwell to 1 while count is 3
      drive_a(0, 2'd2, 4'h0, 0, 0, 8'd5, 16'h0001, 4'd0, 1, 1);
      drive_a(0, 2'd2, 4'h0, 0, 0, 8'd5, 16'h0001, 4'd0, 0, 1);
      drive_a(0, 2'd2, 4'h0, 0, 0, 8'd5, 16'h0001, 4'd0, 0, 1);
      drive_a(0, 2'd2, 4'h0, 0, 0, 8'd5, 16'h0001, 4'd0, 0, 1);
      drive_a(0, 2'd2, 4'h0, 0, 0, 8'd1, 16'h0002, 4'd1, 1, 1);
      drive_a(0, 2'd2, 4'h0, 0, 0, 8'd1, 16'h0002, 4'd1, 0, 1);
      drive_a(0, 2'd2, 4'h0, 0, 0, 8'd1, 16'h0004, 4'd2, 1, 1);
      // Mid-scan switch to input: same channel, no strobe
      drive_a(0, 2'd0, 4'h9, 0, 0, 8'd1, 16'h0004, 4'd2, 0, 0);
      // Re-enter scan: restarts at channel 0
      drive_a(0, 2'd2, 4'h9, 0, 0, 8'd1, 16'h0001, 4'd0, 1, 1);

      // ---------------- Instance B (SEL_W=3) ----------------
      drive_b(1, 2'd1, 3'd0, 0, 8'd1, 8'h00, 3'd0, 0, 0);
      // Scan with dwell=1: each channel held 2 cycles, load pulses ignored
      for (int t = 0; t < 20; t++) begin
         bi = 3'((t / 2) % 8);
         bo = 8'h01 << bi;
         drive_b(0, 2'd2, 3'd5, (t % 4) == 1, 8'd1, bo, bi, (t % 2) == 0, 1);
      end

      // Drain the scoreboard with a bounded wait.
      for (int w = 0; w < 10 && (q_a.size() > 0 || q_b.size() > 0); w++) begin
         @(posedge clk);
         #2;
      end
      checks++;
      if (q_a.size() != 0 || q_b.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d/%0d entries left, want 0/0", q_a.size(), q_b.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/selector_scan_decoder.md
Name: selector_scan_decoder

Overview:
- Parametrised, registered successor to the ROM-page one-hot selector.
- Decodes an SEL_W-bit index into a 2**SEL_W one-hot enable vector.
- Mode 0 (input): captures a selector value on a load strobe.
- Mode 2 (debug): autonomously scans every channel with a programmable dwell time. Modes 1 (run) and 3 (reserved): all enables low.

Parameters:
- SEL_W, 4, index width; channel count N = 2**SEL_W (derived, not overridable).
- DWELL_W, 8, width of the dwell-time input and internal dwell counter.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- mode  input  2  0=input, 1=run, 2=debug (scan), 3=reserved (treated as run)
- selector  input  SEL_W  channel index to capture in input mode
- load  input  1  capture strobe for selector, input mode only
- hold  input  1  freezes scan progression in debug mode
- dwell  input  DWELL_W  scan dwell: each channel held dwell+1 cycles
- out  output  N  registered one-hot enable vector
- index  output  SEL_W  registered current channel index
- strobe  output  1  one-cycle pulse when out takes a new non-zero value
- scanning  output  1  high while in SCAN state

Behaviour:
- Reset dominates all inputs and clears: out=0, index=0, strobe=0, scanning=0, dwell counter=0, state=OFF.
- States are OFF, INPUT and SCAN. Mode is sampled every cycle; next state is INPUT for mode 0, SCAN for mode 2, OFF for modes 1 and 3.
- OFF:
  - out=0 on the next edge; strobe=0.
  - index retains its last value.
- INPUT:
  - load=1: index<=selector and out<=onehot(selector) on the same edge (1-cycle latency from load).
  - load=0: index held; out=onehot(index).
  - Entry from OFF/SCAN without load: out<=onehot(retained index) on the first edge.
  - Entry with load=1 in the same cycle: selector wins.
- SCAN:
  - Entry from another state: index<=0, dwell counter<=0, out<=onehot(0) on the first edge.
  - Each cycle with hold=0: if counter==dwell then index<=index+1 (wraps N-1 -> 0, modulo 2**SEL_W) and counter<=0; else counter<=counter+1.
  - dwell is compared live; lowering dwell below the current count advances on the next cycle and resets the counter.
  - dwell=0: advance every cycle.
  - hold=1: index and counter frozen, out stable; progression resumes from the frozen count.
  - load and selector ignored.
  - scanning=1 registered with state.
- out is always onehot(index) in INPUT/SCAN and exactly zero in OFF; never more than one bit set.
- strobe is registered with out and high for one cycle exactly when the newly registered out is non-zero and differs from the previous out. Cases:
  - load of the same index: no strobe.
  - OFF->INPUT: strobe.
  - every SCAN advance: strobe.
  - N=1 case not supported (SEL_W>=1).
- Mode change mid-dwell: counter discarded; re-entering SCAN always restarts at index 0.
- Reset mid-scan: all outputs zero the following cycle; scan restarts at 0 only when debug mode is next seen.

Test Plan:
- Reset, mode=0, selector=4'hA with load=1 one cycle: next cycle out=16'h0400, index=10, strobe=1 for one cycle. Repeat load of 4'hA: strobe stays 0.
- mode=1 then mode=3 from out=16'h0400: out=0 the next cycle, index stays 10. Return to mode=0 without load: out=16'h0400, strobe=1.
- mode=2, dwell=2: out steps 16'h0001, then 16'h0002, ... each held 3 cycles. After 16'h8000 it wraps to 16'h0001; strobe pulses on each step; scanning=1 throughout.
- mode=2, dwell=0, hold pulsed 4 cycles at index 5: index advances every cycle except frozen at 5 for 4 cycles. Then continues to 6; no strobe during hold.
- rst asserted mid-scan at index 7 with load=1 and mode=0 in the same cycle: next cycle out=0, index=0, strobe=0. The following cycle (load still 1) index=selector.
- SEL_W=3 instance, mode=2, dwell=1: out cycles 8'h01 through 8'h80 every 2 cycles and wraps. Load pulses during the scan are ignored.
